// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED matrix scan driver.
package led_scan_pkg;

   localparam int N_MAX = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } scan_state_t;

   function automatic int col_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/led_col_decoder.sv
// Binary column index to active-high one-hot column select; all zero when disabled.
module led_col_decoder #(
   parameter int N  = 8,
   parameter int CW = 4
) (
   input  logic [CW-1:0] idx,
   input  logic          en,
   output logic [N-1:0]  onehot
);

   always_comb begin
      onehot = '0;
      for (int c = 0; c < N; c++) begin
         if (en && (idx == CW'(c))) onehot[c] = 1'b1;
      end
   end

endmodule

// File: rtl/led_matrix_scanner.sv
// Column-scanning LED matrix driver with double-buffered frames and dwell/blank timing.
// Optional macro LED_SCAN_BRIGHTNESS_EN adds a per-frame brightness (lit-duty) input.
module led_matrix_scanner
   import led_scan_pkg::*;
#(
   parameter int N            = 8,
   parameter int DWELL_CYCLES = 16,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic [N*N-1:0]          cells_in,
   input  logic                    frame_valid,
   output logic                    frame_ready,
   output logic [N-1:0]            rows,
   output logic [N-1:0]            cols,
   output logic [col_width(N)-1:0] col_idx,
   output logic                    frame_done
`ifdef LED_SCAN_BRIGHTNESS_EN
   ,
   input  logic [$clog2(DWELL_CYCLES+1)-1:0] brightness
`endif
);

   localparam int CW = col_width(N);
   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

   if (N < 1 || N > N_MAX) begin : g_bad_n
      $error("led_matrix_scanner: N must be in 1..%0d", N_MAX);
   end
   if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("led_matrix_scanner: DWELL_CYCLES must be >= 1");
   end
   if (BLANK_CYCLES < 0) begin : g_bad_blank
      $error("led_matrix_scanner: BLANK_CYCLES must be >= 0");
   end

   scan_state_t    state, state_nxt;
   logic [DW-1:0]  dwell_cnt, dwell_nxt;
   logic [BW-1:0]  blank_cnt, blank_nxt;
   logic [CW-1:0]  col_nxt;
   logic [N*N-1:0] shadow, shadow_nxt, pending, pending_nxt;
   logic           pend_full, pfull_nxt;
   logic           adv, boundary, show_lit;
   logic [N-1:0]   rows_nxt, cols_nxt;
`ifdef LED_SCAN_BRIGHTNESS_EN
   logic [DW-1:0]  duty, duty_nxt, duty_eff;
`endif

   assign frame_ready = ~pend_full;

   always_comb begin
      state_nxt   = state;
      dwell_nxt   = dwell_cnt;
      blank_nxt   = blank_cnt;
      col_nxt     = col_idx;
      adv         = 1'b0;
      boundary    = 1'b0;
      shadow_nxt  = shadow;
      pending_nxt = pending;
      pfull_nxt   = pend_full;
      rows_nxt    = '1;

      case (state)
         IDLE: begin
            if (ena) begin
               state_nxt = SHOW;
               col_nxt   = '0;
               dwell_nxt = '0;
            end
         end
         SHOW: begin
            if (!ena) begin
               state_nxt = IDLE;
               col_nxt   = '0;
            end else if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
               dwell_nxt = '0;
               if (BLANK_CYCLES > 0) begin
                  state_nxt = BLANK;
                  blank_nxt = '0;
               end else begin
                  adv = 1'b1;
               end
            end else begin
               dwell_nxt = dwell_cnt + DW'(1);
            end
         end
         BLANK: begin
            if (!ena) begin
               state_nxt = IDLE;
               col_nxt   = '0;
            end else if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
               state_nxt = SHOW;
               dwell_nxt = '0;
               adv       = 1'b1;
            end else begin
               blank_nxt = blank_cnt + BW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            col_nxt   = '0;
         end
      endcase

      if (adv) begin
         if (col_idx == CW'(N - 1)) begin
            col_nxt  = '0;
            boundary = 1'b1;
         end else begin
            col_nxt = col_idx + CW'(1);
         end
      end

      // Swap uses the pre-edge pending; an accept can only happen while pending is empty.
      if (boundary && pend_full) begin
         shadow_nxt = pending;
         pfull_nxt  = 1'b0;
      end
      if (frame_valid && !pend_full) begin
         pending_nxt = cells_in;
         pfull_nxt   = 1'b1;
      end

`ifdef LED_SCAN_BRIGHTNESS_EN
      duty_nxt = boundary ? brightness : duty;
      duty_eff = (duty_nxt > DW'(DWELL_CYCLES)) ? DW'(DWELL_CYCLES) : duty_nxt;
      show_lit = (state_nxt == SHOW) && (dwell_nxt < duty_eff);
`else
      show_lit = (state_nxt == SHOW);
`endif

      if (show_lit) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               if (col_nxt == CW'(c)) rows_nxt[r] = ~shadow_nxt[r*N + c];
            end
         end
      end
   end

   led_col_decoder #(.N(N), .CW(CW)) u_col_dec (
      .idx    (col_nxt),
      .en     (show_lit),
      .onehot (cols_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         dwell_cnt  <= '0;
         blank_cnt  <= '0;
         col_idx    <= '0;
         shadow     <= '0;
         pending    <= '0;
         pend_full  <= 1'b0;
         rows       <= '1;
         cols       <= '0;
         frame_done <= 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_EN
         duty       <= DW'(DWELL_CYCLES);
`endif
      end else begin
         state      <= state_nxt;
         dwell_cnt  <= dwell_nxt;
         blank_cnt  <= blank_nxt;
         col_idx    <= col_nxt;
         shadow     <= shadow_nxt;
         pending    <= pending_nxt;
         pend_full  <= pfull_nxt;
         rows       <= rows_nxt;
         cols       <= cols_nxt;
         frame_done <= boundary;
`ifdef LED_SCAN_BRIGHTNESS_EN
         duty       <= duty_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner (N=3, dwell 4, blank 1) against a frame-position reference model.
module tb_led_matrix_scanner;

   localparam int N = 3;
   localparam int D = 4;
   localparam int B = 1;
   localparam int P = N * (D + B);

   logic         clk = 1'b0;
   logic         rst, ena, frame_valid, frame_ready, frame_done;
   logic [8:0]   cells_in;
   logic [2:0]   rows, cols, col_idx;
   logic [2:0]   brightness;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: scan position is cycles since scan start, folded modulo the frame period
   bit         m_run, m_pfull, m_fd;
   int         m_t, m_duty;
   logic [8:0] m_shadow, m_pend;

   always #5 clk = ~clk;

   led_matrix_scanner #(.N(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .cells_in    (cells_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .rows        (rows),
      .cols        (cols),
      .col_idx     (col_idx),
      .frame_done  (frame_done)
`ifdef LED_SCAN_BRIGHTNESS_EN
      ,
      .brightness  (brightness)
`endif
   );

   task automatic tick();
      bit acc;
      @(posedge clk);
      if (!rst) begin
         m_run = 0; m_t = 0; m_shadow = '0; m_pend = '0; m_pfull = 0; m_fd = 0; m_duty = D;
      end else begin
         acc  = frame_valid && !m_pfull;
         m_fd = 0;
         if (!m_run) begin
            if (ena) begin m_run = 1; m_t = 0; end
         end else if (!ena) begin
            m_run = 0;
         end else begin
            m_t++;
            if (m_t % P == 0) begin
               m_fd = 1;
               if (m_pfull) begin m_shadow = m_pend; m_pfull = 0; end
`ifdef LED_SCAN_BRIGHTNESS_EN
               m_duty = int'(brightness);
`endif
            end
         end
         if (acc) begin m_pend = cells_in; m_pfull = 1; end
      end
      #1;
   endtask

   function automatic logic [10:0] exp_vec();
      logic [2:0] r, c;
      int pos, cc, w, ci;
      r = '1; c = '0; ci = 0;
      if (m_run) begin
         pos = m_t % P;
         cc  = pos / (D + B);
         w   = pos % (D + B);
         ci  = cc;
         if (w < D && w < m_duty) begin
            c = 3'(1 << cc);
            for (int rr = 0; rr < N; rr++) r[rr] = ~m_shadow[rr*N + cc];
         end
      end
      return {r, c, 3'(ci), m_fd, ~m_pfull};
   endfunction

   function automatic logic [10:0] obs_vec();
      return {rows, cols, col_idx, frame_done, frame_ready};
   endfunction

   task automatic test_reset();
      rst = 1'b0; ena = 1'b1; frame_valid = 1'b0; cells_in = '0; brightness = 3'd4;
      tick(); tick();
      n_cmp++;
      if ({rows, cols, frame_ready, frame_done} !== 8'b111_000_1_0) begin
         n_err++;
         $display("FAIL reset_vals: got rows=%b cols=%b rdy=%b fd=%b, want 111 000 1 0",
                  rows, cols, frame_ready, frame_done);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec() || cols !== 3'b001 || rows !== 3'b111) begin
         n_err++;
         $display("FAIL reset_first_show: got %b want %b (cols 001 rows 111)", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_diagonal();
      int lit_ok;
      frame_valid = 1'b1; cells_in = 9'b100_010_001;
      tick();
      frame_valid = 1'b0;
      lit_ok = 0;
      for (int i = 0; i < 2*P; i++) begin
         tick();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL diagonal cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
         end
         if (cols != 3'b000 && rows === ~cols) lit_ok++;
      end
      n_cmp++;
      if (lit_ok < N*D) begin
         n_err++;
         $display("FAIL diagonal_lit: got %0d lit diagonal cycles, want at least %0d", lit_ok, N*D);
      end
   endtask

   task automatic test_frame_timing();
      int fd_at[$];
      logic [2:0] ci_hist [0:63];
      for (int i = 0; i < 4*P; i++) begin
         tick();
         ci_hist[i] = col_idx;
         if (frame_done) fd_at.push_back(i);
      end
      n_cmp++;
      if (fd_at.size() < 3) begin
         n_err++;
         $display("FAIL frame_done_count: got %0d pulses want >= 3", fd_at.size());
      end
      for (int k = 1; k < fd_at.size(); k++) begin
         n_cmp++;
         if (fd_at[k] - fd_at[k-1] != P) begin
            n_err++;
            $display("FAIL frame_period: got %0d want %0d", fd_at[k] - fd_at[k-1], P);
         end
      end
      if (fd_at.size() >= 2) begin
         for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (ci_hist[fd_at[0] + s*(D+B)] !== 3'(s % N)) begin
               n_err++;
               $display("FAIL col_seq %0d: got %0d want %0d", s, ci_hist[fd_at[0] + s*(D+B)], s % N);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit b_taken;
      int i;
      frame_valid = 1'b1; cells_in = 9'($urandom);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec() || frame_ready !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_load_a: got %b want %b (ready 0)", obs_vec(), exp_vec());
      end
      cells_in = 9'($urandom);
      b_taken = 0;
      i = 0;
      while (!b_taken && i < 2*P) begin
         b_taken = frame_ready;
         tick();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL b2b_hold cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
         end
         i++;
      end
      n_cmp++;
      if (!b_taken) begin
         n_err++;
         $display("FAIL b2b_timeout: frame B not accepted within %0d cycles", 2*P);
      end
      frame_valid = 1'b0;
      for (int k = 0; k < 2*P; k++) begin
         tick();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL b2b_show cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_enable_drop();
      int i;
      i = 0;
      while (!(col_idx == 3'd1 && cols == 3'b010) && i < 2*P) begin
         tick();
         i++;
      end
      n_cmp++;
      if (i >= 2*P) begin
         n_err++;
         $display("FAIL ena_drop_wait: column 1 not reached within %0d cycles", 2*P);
      end
      ena = 1'b0;
      tick();
      n_cmp++;
      if ({cols, rows, col_idx} !== 9'b000_111_000 || obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL ena_drop: got %b want %b", obs_vec(), exp_vec());
      end
      tick();
      ena = 1'b1;
      for (int k = 0; k < P + 2; k++) begin
         tick();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL ena_restart cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_brightness();
`ifdef LED_SCAN_BRIGHTNESS_EN
      int lit;
      for (int pass = 0; pass < 2; pass++) begin
         brightness = (pass == 0) ? 3'd2 : 3'd0;
         for (int k = 0; k < P; k++) tick();
         lit = 0;
         for (int k = 0; k < P; k++) begin
            tick();
            if (cols != 3'b000) lit++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_err++;
               $display("FAIL bright%0d cyc %0d: got %b want %b", pass, k, obs_vec(), exp_vec());
            end
         end
         n_cmp++;
         if (lit != ((pass == 0) ? N*2 : 0)) begin
            n_err++;
            $display("FAIL bright%0d_lit: got %0d want %0d", pass, lit, (pass == 0) ? N*2 : 0);
         end
      end
      brightness = 3'd4;
`endif
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         rst         = ($urandom_range(0, 199) != 0);
         ena         = ($urandom_range(0, 29) != 0);
         frame_valid = $urandom_range(0, 1);
         cells_in    = 9'($urandom);
         if ($urandom_range(0, 9) == 0) brightness = 3'($urandom_range(0, 5));
         tick();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL random cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
         end
      end
      rst = 1'b1; ena = 1'b1; frame_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_diagonal();
      test_frame_timing();
      test_back_to_back();
      test_enable_drop();
      test_brightness();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
